// File: rtl/pkg_sched.sv
// pkg_sched: N-channel packet-dispatch scheduler, fixed-priority or round-robin.
// Define PKG_SCHED_TIMEOUT_EN to build the WAIT-state done watchdog.
module pkg_sched #(
    parameter int              NCH     = 2,
    parameter int              CH_W    = 1,
    parameter int              RR_MODE = 0,
    parameter int              TO_W    = 16,
    parameter logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}}
) (
    input  logic            clk_sys,
    input  logic            rst_n,
    input  logic [NCH-1:0]  buf_full,
    input  logic [NCH-1:0]  buf_empty,
    output logic [NCH-1:0]  fire,
    input  logic [NCH-1:0]  done,
    output logic            busy,
    output logic [CH_W-1:0] cur_ch,
    output logic            sched_done,
    output logic            timeout_err,
    output logic [CH_W-1:0] err_ch
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FIRE = 3'd1,
        WAIT = 3'd2,
        TOUT = 3'd3,
        DONE = 3'd7
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [CH_W-1:0] rr_ptr;
    logic            sel_vld;
    logic [CH_W-1:0] sel_ch;
    logic            done_cur;
    logic            to_hit;

    if (NCH > 2**CH_W || NCH < 2 || TO_MAX == '0) begin : g_bad_cfg
        $error("pkg_sched: illegal parameter set");
    end

    assign done_cur = done[cur_ch];

    // Round-robin view: status rotated so bit 0 is the channel after rr_ptr.
    logic [CH_W:0]    rr_start;
    logic [2*NCH-1:0] rr_rot;

    always_comb begin
        rr_start = {1'b0, rr_ptr} + (CH_W+1)'(1);
        if (rr_start >= (CH_W+1)'(NCH))
            rr_start = rr_start - (CH_W+1)'(NCH);
        rr_rot = {buf_full, buf_full} >> rr_start;
    end

    always_comb begin
        logic          blk;
        logic [CH_W:0] s;
        sel_vld = 1'b0;
        sel_ch  = '0;
        blk     = 1'b0;
        s       = '0;
        if (RR_MODE != 0) begin
            for (int j = NCH-1; j >= 0; j--) begin
                s = rr_start + (CH_W+1)'(j);
                if (s >= (CH_W+1)'(NCH))
                    s = s - (CH_W+1)'(NCH);
                if (rr_rot[j]) begin
                    sel_vld = 1'b1;
                    sel_ch  = s[CH_W-1:0];
                end
            end
        end else begin
            // A partial buffer ahead in priority holds off everyone below it.
            for (int i = 0; i < NCH; i++) begin
                if (!sel_vld && !blk) begin
                    if (buf_full[i]) begin
                        sel_vld = 1'b1;
                        sel_ch  = CH_W'(i);
                    end else if (!buf_empty[i]) begin
                        blk = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = IDLE;
        unique case (state)
            IDLE:    nxt = sel_vld ? FIRE : IDLE;
            FIRE:    nxt = WAIT;
            WAIT: begin
                if (done_cur)    nxt = DONE;
                else if (to_hit) nxt = TOUT;
                else             nxt = WAIT;
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        fire       = '0;
        busy       = (state != IDLE);
        sched_done = (state == DONE);
        if (state == FIRE)
            fire = NCH'(1) << cur_ch;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cur_ch <= '0;
            rr_ptr <= CH_W'(NCH-1);
        end else begin
            if (state == IDLE && sel_vld)
                cur_ch <= sel_ch;
            if (state == WAIT && nxt != WAIT)
                rr_ptr <= cur_ch;
        end
    end

`ifdef PKG_SCHED_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // Trips in the TO_MAX-th WAIT cycle that lacks done.
    assign to_hit      = (to_cnt + TO_W'(1)) == TO_MAX;
    assign timeout_err = (state == TOUT);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            err_ch <= '0;
        end else begin
            if (state == FIRE)
                to_cnt <= '0;
            else if (state == WAIT && !done_cur)
                to_cnt <= to_cnt + TO_W'(1);
            if (state == WAIT && nxt == TOUT)
                err_ch <= cur_ch;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
    assign err_ch      = '0;
`endif

endmodule

// File: tb/tb_pkg_sched.sv
// tb_pkg_sched: random service traffic on fixed-priority and round-robin
// schedulers, checked cycle by cycle against a transaction-level model.
module tb_pkg_sched;

    localparam int NCH    = 4;
    localparam int TO_LIM = 8;
`ifdef PKG_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic [3:0] bf [2];
    logic [3:0] be [2];
    logic [3:0] dn [2];
    logic [3:0] fi [2];
    logic       bz [2];
    logic       sd [2];
    logic       te [2];
    logic [1:0] cc [2];
    logic [1:0] ec [2];

    int n_chk  = 0;
    int n_pass = 0;
    int rr_m  [2];
    int err_m [2];

    always #5 clk_sys = ~clk_sys;

    pkg_sched #(
        .NCH(NCH), .CH_W(2), .RR_MODE(0), .TO_W(16), .TO_MAX(16'd8)
    ) u_fp (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .buf_full(bf[0]), .buf_empty(be[0]), .fire(fi[0]), .done(dn[0]),
        .busy(bz[0]), .cur_ch(cc[0]), .sched_done(sd[0]),
        .timeout_err(te[0]), .err_ch(ec[0])
    );

    pkg_sched #(
        .NCH(NCH), .CH_W(2), .RR_MODE(1), .TO_W(16), .TO_MAX(16'd8)
    ) u_rr (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .buf_full(bf[1]), .buf_empty(be[1]), .fire(fi[1]), .done(dn[1]),
        .busy(bz[1]), .cur_ch(cc[1]), .sched_done(sd[1]),
        .timeout_err(te[1]), .err_ch(ec[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Which channel should be picked, or -1 for none.
    function automatic int model_sel(input int k, input logic [3:0] f,
                                     input logic [3:0] e);
        if (k == 1) begin
            for (int n = 1; n <= NCH; n++)
                if (f[(rr_m[k] + n) % NCH]) return (rr_m[k] + n) % NCH;
            return -1;
        end
        for (int c = 0; c < NCH; c++) begin
            if (f[c]) return c;
            if (!e[c]) return -1;
        end
        return -1;
    endfunction

    task automatic service(input int k, input logic [3:0] f,
                           input logic [3:0] e, input int d,
                           input bit early);
        int ch;
        logic [3:0] oth;
        bf[k] = f;
        be[k] = e;
        ch = model_sel(k, f, e);
        tick();
        if (ch < 0) begin
            check("idle_fire", fi[k], 0);
            check("idle_busy", bz[k], 0);
            bf[k] = '0;
            be[k] = '0;
            return;
        end
        check("fire", fi[k], 32'(1) << ch);
        check("cur_ch", cc[k], ch);
        check("busy_fire", bz[k], 1);
        bf[k] = 4'($urandom);
        be[k] = 4'($urandom);
        dn[k] = early ? 4'(32'(1) << ch) : 4'b0;
        tick();
        check("fire_pulse", fi[k], 0);
        for (int i = 1; i <= 20; i++) begin
            oth = 4'($urandom) & ~4'(32'(1) << ch);
            dn[k] = oth | ((i == d) ? 4'(32'(1) << ch) : 4'b0);
            tick();
            dn[k] = '0;
            if (i == d) begin
                check("sched_done", sd[k], 1);
                check("no_tout", te[k], 0);
                rr_m[k] = ch;
                break;
            end
            if (TO_EN && i == TO_LIM) begin
                check("timeout_err", te[k], 1);
                check("err_ch", ec[k], ch);
                check("tout_no_done", sd[k], 0);
                rr_m[k]  = ch;
                err_m[k] = ch;
                break;
            end
            check("wait_busy", bz[k], 1);
            check("wait_no_done", sd[k], 0);
            if (i == 20) check("wait_bound", 0, 1);
        end
        tick();
        bf[k] = '0;
        be[k] = '0;
        check("back_idle", bz[k], 0);
        check("idle_sd", sd[k], 0);
        check("idle_te", te[k], 0);
        check("err_hold", ec[k], err_m[k]);
    endtask

    initial begin
        int k;
        int d;
        rst_n = 1'b0;
        for (int j = 0; j < 2; j++) begin
            bf[j] = '0;
            be[j] = '0;
            dn[j] = '0;
            rr_m[j]  = NCH - 1;
            err_m[j] = 0;
        end
        repeat (3) tick();
        for (int j = 0; j < 2; j++) begin
            check("rst_fire", fi[j], 0);
            check("rst_busy", bz[j], 0);
            check("rst_cur", cc[j], 0);
            check("rst_sd", sd[j], 0);
            check("rst_te", te[j], 0);
            check("rst_errch", ec[j], 0);
        end
        rst_n = 1'b1;
        tick();

        service(0, 4'b0001, 4'b0000, 3, 1'b0);
        service(0, 4'b1000, 4'b0110, 1, 1'b0);
        service(0, 4'b1000, 4'b0111, 1, 1'b0);
        service(0, 4'b0100, 4'b0111, 2, 1'b0);
        service(0, 4'b0001, 4'b0001, 1, 1'b1);
        for (int j = 0; j < 5; j++)
            service(1, 4'b1111, 4'b0000, 1, 1'b0);
        service(1, 4'b0010, 4'b0000, 4, 1'b0);
        service(0, 4'b0010, 4'b0001, 12, 1'b0);
        service(1, 4'b0100, 4'b0000, TO_LIM, 1'b0);

        for (int n = 0; n < 200; n++) begin
            k = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) d = int'($urandom_range(7, 12));
            else                           d = int'($urandom_range(1, 4));
            service(k, 4'($urandom), 4'($urandom), d,
                    $urandom_range(0, 4) == 0);
        end

        bf[1] = 4'b0100;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", bz[1], 0);
        check("arst_fire", fi[1], 0);
        check("arst_cur", cc[1], 0);
        check("arst_sd", sd[1], 0);
        check("arst_errch", ec[1], 0);
        bf[1] = '0;
        #2 rst_n = 1'b1;
        for (int j = 0; j < 2; j++) begin
            rr_m[j]  = NCH - 1;
            err_m[j] = 0;
        end
        tick();
        service(1, 4'b1111, 4'b0000, 1, 1'b0);
        service(0, 4'b0110, 4'b0001, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
